// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the unified memory.
// The slave view is the arbiter; the master view is everything around it.
interface unified_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              stall_f;
  logic              stall_m;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, d_rdata, d_done, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, d_rdata, d_done, stall_f, stall_m,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter: fetch vs. data (data wins), one access in flight,
// registered memory request, done pulses with captured read data, and a no-response watchdog.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus
);
  localparam bit          WD_EN = (TIMEOUT > 0);
  localparam int unsigned CNT_W = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, D_BUSY = 2'd1, I_BUSY = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic              d_elig, i_elig, wd_expire, finish;
  logic [DATA_W-1:0] rsp_data;

  // Next-state, memory request and response capture
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = bus_err_q;
    wd_cnt_d    = wd_cnt_q;

    // A request still high during its own done cycle is stale.
    d_elig    = bus.d_req & ~d_done_q;
    i_elig    = bus.if_req & ~if_done_q;
    wd_expire = WD_EN && (state_q != IDLE) && !bus.mem_ready && (wd_cnt_q == CNT_LAST);
    finish    = bus.mem_ready | wd_expire;
    rsp_data  = bus.mem_ready ? bus.mem_rdata : '0;

    case (state_q)
      IDLE: begin
        if (d_elig) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          wd_cnt_d    = '0;
        end else if (i_elig) begin
          state_d    = I_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          wd_cnt_d   = '0;
        end
      end
      D_BUSY, I_BUSY: begin
        if (finish) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          bus_err_d = bus_err_q | wd_expire;
          if (state_q == D_BUSY) begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_rdata_d = rsp_data;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = rsp_data;
          end
        end else if (WD_EN) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_f   = bus.if_req & ~if_done_q;
  assign bus.stall_m   = bus.d_req & ~d_done_q;
endmodule
